// File: rtl/prco_mem_ctrl_if.sv
// Bus bundle between the core pipeline / local memory and prco_mem_ctrl.
// The controller uses the master view; the pipeline and lmem side use the slave view.
interface prco_mem_ctrl_if;
  logic        i_fetch_req;
  logic [15:0] i_pc;
  logic        i_data_req;
  logic        i_data_we;
  logic [15:0] i_data_addr;
  logic [15:0] i_data_wdata;
  logic        q_ready;
  logic [15:0] q_instr;
  logic        q_instr_valid;
  logic [15:0] q_rdata;
  logic        q_rdata_valid;
  logic        q_wr_done;
  logic        q_overflow;
  logic        q_err_timeout;
  logic        q_ce_fetch;
  logic        q_ce_alu;
  logic        q_mem_we;
  logic [15:0] q_mem_addr;
  logic [15:0] q_mem_dina;
  logic        i_ce_dec;
  logic        i_ce_reg;
  logic [15:0] i_mem_douta;

  modport master (
    input  i_fetch_req, i_pc, i_data_req, i_data_we, i_data_addr, i_data_wdata,
    input  i_ce_dec, i_ce_reg, i_mem_douta,
    output q_ready, q_instr, q_instr_valid, q_rdata, q_rdata_valid, q_wr_done,
    output q_overflow, q_err_timeout, q_ce_fetch, q_ce_alu, q_mem_we, q_mem_addr, q_mem_dina
  );

  modport slave (
    output i_fetch_req, i_pc, i_data_req, i_data_we, i_data_addr, i_data_wdata,
    output i_ce_dec, i_ce_reg, i_mem_douta,
    input  q_ready, q_instr, q_instr_valid, q_rdata, q_rdata_valid, q_wr_done,
    input  q_overflow, q_err_timeout, q_ce_fetch, q_ce_alu, q_mem_we, q_mem_addr, q_mem_dina
  );
endinterface

// File: rtl/prco_mem_ctrl.sv
// Local-memory initiator: one access in flight plus one buffered request, fetch and
// LW/SW arbitration (data first), response matching and a WAIT timeout.
module prco_mem_ctrl #(
  parameter int P_TIMEOUT = 7
) (
  input  logic            i_clk,
  input  logic            i_rst,
  prco_mem_ctrl_if.master bus
);
  localparam int CNT_W = $clog2(P_TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               pnd_full_q, pnd_full_d;
  logic               iss_fetch_q, iss_fetch_d, iss_we_q, iss_we_d;
  logic [15:0]        iss_addr_q, iss_addr_d, iss_wdata_q, iss_wdata_d;
  logic               pnd_fetch_q, pnd_fetch_d, pnd_we_q, pnd_we_d;
  logic [15:0]        pnd_addr_q, pnd_addr_d, pnd_wdata_q, pnd_wdata_d;
  logic               ready_q, ready_d, overflow_q, overflow_d, err_q, err_d;
  logic               ce_fetch_q, ce_fetch_d, ce_alu_q, ce_alu_d, mem_we_q, mem_we_d;
  logic [15:0]        mem_addr_q, mem_addr_d, mem_dina_q, mem_dina_d;
  logic [15:0]        instr_q, instr_d, rdata_q, rdata_d;
  logic               instr_vld_q, instr_vld_d, rdata_vld_q, rdata_vld_d, wr_done_q, wr_done_d;
  logic               any_req, match, done, take_new, buffer_new;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pnd_full_d  = pnd_full_q;
    iss_fetch_d = iss_fetch_q;
    iss_we_d    = iss_we_q;
    iss_addr_d  = iss_addr_q;
    iss_wdata_d = iss_wdata_q;
    pnd_fetch_d = pnd_fetch_q;
    pnd_we_d    = pnd_we_q;
    pnd_addr_d  = pnd_addr_q;
    pnd_wdata_d = pnd_wdata_q;
    overflow_d  = overflow_q;
    err_d       = err_q;
    ce_fetch_d  = 1'b0;
    ce_alu_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_dina_d  = mem_dina_q;
    instr_d     = instr_q;
    rdata_d     = rdata_q;
    instr_vld_d = 1'b0;
    rdata_vld_d = 1'b0;
    wr_done_d   = 1'b0;
    any_req     = bus.i_fetch_req | bus.i_data_req;
    match       = iss_fetch_q ? bus.i_ce_dec : bus.i_ce_reg;
    done        = 1'b0;
    take_new    = 1'b0;
    buffer_new  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (any_req) begin
          take_new = 1'b1;
          state_d  = S_ISSUE;
          // Data wins the issue slot; a simultaneous fetch goes to the pending slot.
          if (bus.i_data_req && bus.i_fetch_req) begin
            pnd_full_d  = 1'b1;
            pnd_fetch_d = 1'b1;
            pnd_we_d    = 1'b0;
            pnd_addr_d  = bus.i_pc;
          end
        end
      end
      S_ISSUE: begin
        // Strobes are registered here, so the lmem sees them in the following cycle.
        ce_fetch_d = iss_fetch_q;
        ce_alu_d   = ~iss_fetch_q;
        mem_we_d   = ~iss_fetch_q & iss_we_q;
        mem_addr_d = iss_addr_q;
        mem_dina_d = iss_wdata_q;
        cnt_d      = '0;
        state_d    = S_WAIT;
        buffer_new = 1'b1;
      end
      S_WAIT: begin
        done  = match || (cnt_q == CNT_W'(P_TIMEOUT - 1));
        cnt_d = cnt_q + CNT_W'(1);
        if (match) begin
          if (iss_fetch_q) begin
            instr_d     = bus.i_mem_douta;
            instr_vld_d = 1'b1;
          end else if (iss_we_q) begin
            wr_done_d   = 1'b1;
          end else begin
            rdata_d     = bus.i_mem_douta;
            rdata_vld_d = 1'b1;
          end
        end else if (done) begin
          err_d = 1'b1;
        end
        if (!done) begin
          buffer_new = 1'b1;
        end else if (pnd_full_q) begin
          // The slot frees on this edge but cannot be refilled until the next one.
          iss_fetch_d = pnd_fetch_q;
          iss_we_d    = pnd_we_q;
          iss_addr_d  = pnd_addr_q;
          iss_wdata_d = pnd_wdata_q;
          pnd_full_d  = 1'b0;
          state_d     = S_ISSUE;
          if (any_req) overflow_d = 1'b1;
        end else if (any_req) begin
          take_new = 1'b1;
          state_d  = S_ISSUE;
          if (bus.i_data_req && bus.i_fetch_req) overflow_d = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (take_new) begin
      if (bus.i_data_req) begin
        iss_fetch_d = 1'b0;
        iss_we_d    = bus.i_data_we;
        iss_addr_d  = bus.i_data_addr;
        iss_wdata_d = bus.i_data_wdata;
      end else begin
        iss_fetch_d = 1'b1;
        iss_we_d    = 1'b0;
        iss_addr_d  = bus.i_pc;
      end
    end

    if (buffer_new && any_req) begin
      if (pnd_full_q) begin
        overflow_d = 1'b1;
      end else begin
        pnd_full_d = 1'b1;
        if (bus.i_data_req) begin
          pnd_fetch_d = 1'b0;
          pnd_we_d    = bus.i_data_we;
          pnd_addr_d  = bus.i_data_addr;
          pnd_wdata_d = bus.i_data_wdata;
          if (bus.i_fetch_req) overflow_d = 1'b1;
        end else begin
          pnd_fetch_d = 1'b1;
          pnd_we_d    = 1'b0;
          pnd_addr_d  = bus.i_pc;
        end
      end
    end

    ready_d = ~pnd_full_d;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      pnd_full_q  <= 1'b0;
      ready_q     <= 1'b1;
      overflow_q  <= 1'b0;
      err_q       <= 1'b0;
      ce_fetch_q  <= 1'b0;
      ce_alu_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_dina_q  <= '0;
      instr_q     <= '0;
      rdata_q     <= '0;
      instr_vld_q <= 1'b0;
      rdata_vld_q <= 1'b0;
      wr_done_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pnd_full_q  <= pnd_full_d;
      ready_q     <= ready_d;
      overflow_q  <= overflow_d;
      err_q       <= err_d;
      ce_fetch_q  <= ce_fetch_d;
      ce_alu_q    <= ce_alu_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_dina_q  <= mem_dina_d;
      instr_q     <= instr_d;
      rdata_q     <= rdata_d;
      instr_vld_q <= instr_vld_d;
      rdata_vld_q <= rdata_vld_d;
      wr_done_q   <= wr_done_d;
    end
  end

  // Request payload is only consumed under valid control state, so it needs no reset.
  always_ff @(posedge i_clk) begin
    iss_fetch_q <= iss_fetch_d;
    iss_we_q    <= iss_we_d;
    iss_addr_q  <= iss_addr_d;
    iss_wdata_q <= iss_wdata_d;
    pnd_fetch_q <= pnd_fetch_d;
    pnd_we_q    <= pnd_we_d;
    pnd_addr_q  <= pnd_addr_d;
    pnd_wdata_q <= pnd_wdata_d;
  end

  assign bus.q_ready       = ready_q;
  assign bus.q_instr       = instr_q;
  assign bus.q_instr_valid = instr_vld_q;
  assign bus.q_rdata       = rdata_q;
  assign bus.q_rdata_valid = rdata_vld_q;
  assign bus.q_wr_done     = wr_done_q;
  assign bus.q_overflow    = overflow_q;
  assign bus.q_err_timeout = err_q;
  assign bus.q_ce_fetch    = ce_fetch_q;
  assign bus.q_ce_alu      = ce_alu_q;
  assign bus.q_mem_we      = mem_we_q;
  assign bus.q_mem_addr    = mem_addr_q;
  assign bus.q_mem_dina    = mem_dina_q;
endmodule
